// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event monitor.
//   MODE_*        : per-channel qualifier encodings (2 bits per channel)
//   arm_state_e   : state encoding of the shared arm FSM
//   ARM_CNT_W     : width of the arm counter (covers SYNC_STAGES up to 3)
//   mode_qualifies: selects the transition that counts as an event for a mode
package edge_event_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_ANY  = 2'b11;

    localparam int unsigned ARM_CNT_W = 2;

    typedef enum logic [0:0] {
        StPrime = 1'b0,
        StRun   = 1'b1
    } arm_state_e;

    function automatic logic mode_qualifies(input logic [1:0] mode,
                                            input logic       rise,
                                            input logic       fall);
        logic q;
        q = 1'b0;
        case (mode)
            MODE_RISE: q = rise;
            MODE_FALL: q = fall;
            MODE_ANY:  q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/event_channel.sv
// One monitored channel: synchroniser, previous-value flop, edge qualification,
// sticky pending/overflow flags and a saturating event counter.
//   clk, rst  : clock and synchronous active-high reset
//   sig_in    : asynchronous (or already synchronous when SYNC_STAGES = 0) input
//   mode      : qualifier, see MODE_* in edge_event_pkg
//   ack       : clears pending and overflow (an event in the same cycle wins)
//   cnt_clr   : clears the counter (an event in the same cycle leaves it at 1)
//   arm       : high once the shared arm FSM has left its priming phase
//   evt_pulse : one-cycle registered pulse per qualified event
//   pending   : sticky event flag
//   overflow  : sticky flag, event seen while pending was still set
//   evt_cnt   : saturating event count
module event_channel
    import edge_event_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic [1:0]       mode,
    input  logic             ack,
    input  logic             cnt_clr,
    input  logic             arm,
    output logic             evt_pulse,
    output logic             pending,
    output logic             overflow,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic cur;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign cur = sig_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign cur = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic             prev_q;
    logic             pulse_q, pulse_d;
    logic             pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise, fall, evt;

    assign rise = cur & ~prev_q;
    assign fall = ~cur & prev_q;
    // prev keeps tracking during priming so the first armed cycle compares
    // two settled samples and a static input never looks like an edge.
    assign evt  = arm & mode_qualifies(mode, rise, fall);

    always_comb begin
        pulse_d    = evt;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;

        if (evt) begin
            pending_d = 1'b1;
        end else if (ack) begin
            pending_d = 1'b0;
        end

        // ack in the same cycle as an event clears overflow rather than setting it
        if (ack) begin
            overflow_d = 1'b0;
        end else if (evt && pending_q) begin
            overflow_d = 1'b1;
        end

        if (cnt_clr) begin
            cnt_d = evt ? CNT_ONE : '0;
        end else if (evt && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= 1'b0;
            pulse_q    <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            prev_q     <= cur;
            pulse_q    <= pulse_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    assign evt_pulse = pulse_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign evt_cnt   = cnt_q;

endmodule

// File: rtl/edge_event_monitor.sv
// Multi-channel change detector with a shared arm FSM and combined interrupt.
//   clk, rst  : clock and synchronous active-high reset
//   sig_in    : CHANNELS monitored inputs
//   mode      : 2 bits per channel, channel i in [2i+1:2i]
//   ack       : per-channel pending/overflow clear
//   cnt_clr   : per-channel counter clear
//   evt_pulse : per-channel one-cycle event pulse
//   pending   : per-channel sticky event flag
//   overflow  : per-channel sticky overflow flag
//   evt_cnt   : per-channel saturating counts, channel i in [CNT_W*(i+1)-1:CNT_W*i]
//   irq       : OR of all pending bits
module edge_event_monitor
    import edge_event_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sig_in,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       ack,
    input  logic [CHANNELS-1:0]       cnt_clr,
    output logic [CHANNELS-1:0]       evt_pulse,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS-1:0]       overflow,
    output logic [CHANNELS*CNT_W-1:0] evt_cnt,
    output logic                      irq
);

    // Priming lasts SYNC_STAGES+1 edges: enough to flush the synchroniser and
    // load prev from a valid sample before any event may qualify.
    localparam logic [ARM_CNT_W-1:0] ARM_LAST = ARM_CNT_W'(SYNC_STAGES);

    arm_state_e           state_q, state_d;
    logic [ARM_CNT_W-1:0] arm_cnt_q, arm_cnt_d;
    logic                 arm;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        case (state_q)
            StPrime: begin
                if (arm_cnt_q == ARM_LAST) begin
                    state_d = StRun;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StPrime;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StPrime;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign arm = (state_q == StRun);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        event_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .sig_in    (sig_in[i]),
            .mode      (mode[2*i+1:2*i]),
            .ack       (ack[i]),
            .cnt_clr   (cnt_clr[i]),
            .arm       (arm),
            .evt_pulse (evt_pulse[i]),
            .pending   (pending[i]),
            .overflow  (overflow[i]),
            .evt_cnt   (evt_cnt[CNT_W*(i+1)-1:CNT_W*i])
        );
    end

    assign irq = |pending;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Self-checking bench: instance a uses the default parameters (4 ch, 8-bit
// counters, 2 sync stages); instance b uses 2-bit counters and no synchroniser.
module tb_edge_event_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a
    logic        rst_a;
    logic [3:0]  sig_a, ack_a, clr_a;
    logic [7:0]  mode_a;
    logic [3:0]  pulse_a, pend_a, ovf_a;
    logic [31:0] cnt_a;
    logic        irq_a;

    edge_event_monitor #(
        .CHANNELS    (4),
        .CNT_W       (8),
        .SYNC_STAGES (2)
    ) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .sig_in    (sig_a),
        .mode      (mode_a),
        .ack       (ack_a),
        .cnt_clr   (clr_a),
        .evt_pulse (pulse_a),
        .pending   (pend_a),
        .overflow  (ovf_a),
        .evt_cnt   (cnt_a),
        .irq       (irq_a)
    );

    // Instance b
    logic        rst_b;
    logic [3:0]  sig_b, ack_b, clr_b;
    logic [7:0]  mode_b;
    logic [3:0]  pulse_b, pend_b, ovf_b;
    logic [7:0]  cnt_b;
    logic        irq_b;

    edge_event_monitor #(
        .CHANNELS    (4),
        .CNT_W       (2),
        .SYNC_STAGES (0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .sig_in    (sig_b),
        .mode      (mode_b),
        .ack       (ack_b),
        .cnt_clr   (clr_b),
        .evt_pulse (pulse_b),
        .pending   (pend_b),
        .overflow  (ovf_b),
        .evt_cnt   (cnt_b),
        .irq       (irq_b)
    );

    typedef struct packed {
        logic [3:0]  pulse;
        logic [3:0]  pend;
        logic [3:0]  ovf;
        logic [31:0] cnt;
    } exp_a_t;

    typedef struct packed {
        logic [3:0] sig;
        logic [7:0] mode;
        logic [3:0] ack;
        logic [3:0] clr;
        exp_a_t     exp;
    } vec_t;

    typedef struct packed {
        logic [3:0] pulse;
        logic [7:0] cnt;
    } exp_b_t;

    exp_a_t sb_a[$];
    exp_b_t sb_b[$];
    vec_t   tbl[23];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_a();
        exp_a_t e;
        n_vec++;
        if (sb_a.size() == 0) begin
            n_err++;
            $display("FAIL a_scoreboard at %0t: got empty queue, expected an entry", $time);
            return;
        end
        e = sb_a.pop_front();
        chk("a_evt_pulse", {28'd0, pulse_a}, {28'd0, e.pulse});
        chk("a_pending",   {28'd0, pend_a},  {28'd0, e.pend});
        chk("a_overflow",  {28'd0, ovf_a},   {28'd0, e.ovf});
        chk("a_irq",       {31'd0, irq_a},   {31'd0, |e.pend});
        chk("a_evt_cnt",   cnt_a,            e.cnt);
    endtask

    // Drive one cycle of inputs, record the outputs expected after the next edge.
    task automatic drive_a(input logic [3:0] s, input logic [7:0] m, input logic [3:0] ak,
                           input logic [3:0] cl, input exp_a_t e);
        sig_a  = s;
        mode_a = m;
        ack_a  = ak;
        clr_a  = cl;
        sb_a.push_back(e);
        @(posedge clk);
        #1;
        check_a();
    endtask

    task automatic check_b();
        exp_b_t e;
        n_vec++;
        if (sb_b.size() == 0) begin
            n_err++;
            $display("FAIL b_scoreboard at %0t: got empty queue, expected an entry", $time);
            return;
        end
        e = sb_b.pop_front();
        chk("b_evt_pulse", {28'd0, pulse_b}, {28'd0, e.pulse});
        chk("b_evt_cnt",   {24'd0, cnt_b},   {24'd0, e.cnt});
    endtask

    task automatic drive_b(input logic [3:0] s, input logic [3:0] cl, input exp_b_t e);
        sig_b = s;
        clr_b = cl;
        sb_b.push_back(e);
        @(posedge clk);
        #1;
        check_b();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_a_t ea;
        exp_b_t eb;
        int     c;

        // Expected outputs after the edge on which each row is applied; sig_in
        // of row j shows up in the outputs of row j+2.
        tbl[0]  = '{4'b0011, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 4'b0000, 32'h00000000}};
        tbl[1]  = '{4'b0011, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 4'b0000, 32'h00000000}};
        tbl[2]  = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0001, 4'b0001, 4'b0000, 32'h00000001}};
        tbl[3]  = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0001, 4'b0000, 32'h00000001}};
        tbl[4]  = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0010, 4'b0011, 4'b0000, 32'h00000101}};
        tbl[5]  = '{4'b0100, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0011, 4'b0000, 32'h00000101}};
        tbl[6]  = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0011, 4'b0000, 32'h00000101}};
        tbl[7]  = '{4'b0000, 8'h39, 4'b0011, 4'b0000, '{4'b0100, 4'b0100, 4'b0000, 32'h00010101}};
        tbl[8]  = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0100, 4'b0100, 4'b0100, 32'h00020101}};
        tbl[9]  = '{4'b0000, 8'h39, 4'b0100, 4'b0000, '{4'b0000, 4'b0000, 4'b0000, 32'h00020101}};
        tbl[10] = '{4'b0100, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 4'b0000, 32'h00020101}};
        tbl[11] = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 4'b0000, 32'h00020101}};
        tbl[12] = '{4'b0100, 8'h39, 4'b0000, 4'b0000, '{4'b0100, 4'b0100, 4'b0000, 32'h00030101}};
        tbl[13] = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0100, 4'b0100, 4'b0100, 32'h00040101}};
        tbl[14] = '{4'b0000, 8'h39, 4'b0100, 4'b0100, '{4'b0100, 4'b0100, 4'b0000, 32'h00010101}};
        tbl[15] = '{4'b0000, 8'h39, 4'b0000, 4'b0001, '{4'b0100, 4'b0100, 4'b0100, 32'h00020100}};
        tbl[16] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, '{4'b0000, 4'b0100, 4'b0100, 32'h00020100}};
        tbl[17] = '{4'b0011, 8'h00, 4'b0000, 4'b0000, '{4'b0000, 4'b0100, 4'b0100, 32'h00020100}};
        tbl[18] = '{4'b0011, 8'h00, 4'b0000, 4'b0000, '{4'b0000, 4'b0100, 4'b0100, 32'h00020100}};
        tbl[19] = '{4'b0000, 8'h00, 4'b0000, 4'b0000, '{4'b0000, 4'b0100, 4'b0100, 32'h00020100}};
        tbl[20] = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0000, 4'b0100, 4'b0100, 32'h00020100}};
        tbl[21] = '{4'b0000, 8'h39, 4'b0000, 4'b0000, '{4'b0010, 4'b0110, 4'b0100, 32'h00020200}};
        tbl[22] = '{4'b0000, 8'h39, 4'b1111, 4'b0000, '{4'b0000, 4'b0000, 4'b0000, 32'h00020200}};

        rst_a = 1'b1; sig_a = 4'b1111; mode_a = 8'hFF; ack_a = '0; clr_a = '0;
        rst_b = 1'b1; sig_b = 4'b0000; mode_b = 8'hFF; ack_b = '0; clr_b = '0;

        // Static-high inputs through reset: reset state, then no spurious events.
        ea = '{4'b0000, 4'b0000, 4'b0000, 32'h0};
        drive_a(4'b1111, 8'hFF, 4'b0000, 4'b0000, ea);
        drive_a(4'b1111, 8'hFF, 4'b0000, 4'b0000, ea);
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) drive_a(4'b1111, 8'hFF, 4'b0000, 4'b0000, ea);

        // Falls with every channel off must not register.
        for (int i = 0; i < 4; i++) drive_a(4'b0000, 8'h00, 4'b0000, 4'b0000, ea);

        // Latency, per-mode qualification, pending/overflow/ack, cnt_clr, mode off.
        for (int i = 0; i < 23; i++) begin
            drive_a(tbl[i].sig, tbl[i].mode, tbl[i].ack, tbl[i].clr, tbl[i].exp);
        end

        // Back-to-back on ch3 through the synchroniser: 8 toggles, 8 pulses.
        for (int i = 0; i < 11; i++) begin
            c = (i < 2) ? 0 : ((i - 1 > 8) ? 8 : i - 1);
            ea.pulse = (i >= 2 && i <= 9) ? 4'b1000 : 4'b0000;
            ea.pend  = (i >= 2) ? 4'b1000 : 4'b0000;
            ea.ovf   = (i >= 3) ? 4'b1000 : 4'b0000;
            ea.cnt   = {c[7:0], 8'd2, 8'd2, 8'd0};
            drive_a((i < 8) ? {~i[0], 3'b000} : 4'b0000, 8'hC0, 4'b0000, 4'b0000, ea);
        end

        // Mid-operation reset, then a held change during priming is ignored.
        rst_a = 1'b1;
        ea = '{4'b0000, 4'b0000, 4'b0000, 32'h0};
        drive_a(4'b0000, 8'hFF, 4'b0000, 4'b0000, ea);
        rst_a = 1'b0;
        for (int i = 0; i < 6; i++) drive_a(4'b0100, 8'hFF, 4'b0000, 4'b0000, ea);
        // Armed again: a fall is seen two edges later.
        drive_a(4'b0000, 8'hFF, 4'b0000, 4'b0000, ea);
        drive_a(4'b0000, 8'hFF, 4'b0000, 4'b0000, ea);
        drive_a(4'b0000, 8'hFF, 4'b0000, 4'b0000, '{4'b0100, 4'b0100, 4'b0000, 32'h00010000});

        // Instance b: zero-latency detection and 2-bit saturation.
        eb = '{4'b0000, 8'h00};
        drive_b(4'b0000, 4'b0000, eb);
        rst_b = 1'b0;
        drive_b(4'b0000, 4'b0000, eb);
        drive_b(4'b0000, 4'b0000, eb);
        for (int i = 0; i < 5; i++) begin
            c = (i + 1 > 3) ? 3 : i + 1;
            eb = '{4'b0011, {4'b0000, c[1:0], c[1:0]}};
            drive_b(i[0] ? 4'b0000 : 4'b0011, 4'b0000, eb);
        end
        eb = '{4'b0000, 8'b0000_1111};
        drive_b(4'b0011, 4'b0000, eb);
        drive_b(4'b0011, 4'b0000, eb);
        // Clear coincident with an event leaves 1; ch1 stays saturated.
        drive_b(4'b0000, 4'b0001, '{4'b0011, 8'b0000_1101});
        drive_b(4'b0000, 4'b0010, '{4'b0000, 8'b0000_0001});
        // ch3 toggled every cycle: continuous pulse train.
        for (int i = 0; i < 8; i++) begin
            c = (i + 1 > 3) ? 3 : i + 1;
            eb = '{4'b1000, {c[1:0], 6'b00_00_01}};
            drive_b({~i[0], 3'b000}, 4'b0000, eb);
        end
        drive_b(4'b0000, 4'b0000, '{4'b0000, 8'b1100_0001});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edge_event_monitor.md
# edge_event_monitor

Parametrised multi-channel change detector generalising the "execute on change of a or b" sensitivity-list idea into synthesizable clocked logic. Each channel synchronises an asynchronous input, detects qualified transitions (rise, fall or any), and reports them as a pulse, a sticky pending flag and a saturating event count. A combined interrupt line serves the control/status logic in the same design.

## Interface
- `CHANNELS`, 4: number of monitored inputs, 1..32.
- `CNT_W`, 8: event counter width per channel, 2..16.
- `SYNC_STAGES`, 2: synchroniser flops per input, 0..3. 0 means the input is already synchronous.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sig_in`  in  CHANNELS  monitored signals.
- `mode`  in  2*CHANNELS  per-channel qualifier in bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 any.
- `ack`  in  CHANNELS  per-channel pending/overflow clear, level-sampled each cycle.
- `cnt_clr`  in  CHANNELS  per-channel counter clear.
- `evt_pulse`  out  CHANNELS  one-cycle pulse per qualified event.
- `pending`  out  CHANNELS  sticky event flag.
- `overflow`  out  CHANNELS  sticky flag: event arrived while pending already set.
- `evt_cnt`  out  CHANNELS*CNT_W  saturating counts; channel i in [CNT_W*(i+1)-1 : CNT_W*i].
- `irq`  out  1  OR of all `pending` bits.

## Operation
- Per channel: `sig_in` → SYNC_STAGES flops → `cur`; `prev` holds `cur` from the previous cycle.
- Rise = `cur & ~prev`; fall = `~cur & prev`; qualified event = the transition selected by `mode`. Mode 00 never qualifies.
- Arm FSM (shared): states PRIME, RUN.
  - Reset → PRIME, with the arm counter at 0.
  - In PRIME, sync flops and `prev` load normally but events are suppressed. After SYNC_STAGES+1 edges → RUN.
  - RUN is held until `rst`. No spurious event for an input that is static-high at reset release.
- On a qualified event:
  - `evt_pulse`=1 for exactly one cycle.
  - `pending` set.
  - `evt_cnt` incremented, saturating at 2^CNT_W−1 and holding there.
- `overflow` is set when an event occurs with `pending`=1 and `ack`=0 in the same cycle.
- `ack`: clears `pending` and `overflow` next edge.
  - If `ack` coincides with an event, the event wins: `pending` stays 1, `overflow` is not set, and `overflow` is cleared.
- `cnt_clr` forces `evt_cnt` to 0. If it coincides with an event, the result is 1.
- A `mode` change takes effect on the next detection cycle and is never retroactive. Switching to 00 retains `pending`, `overflow` and the count.
- `irq` is combinational OR of the registered `pending` bits, so it is glitch-free relative to `clk`.
- Channels are independent; any number may fire in the same cycle.

## Timing
- Reset values: `evt_pulse`=0, `pending`=0, `overflow`=0, `evt_cnt`=0, `irq`=0. Sync flops, `prev` and the arm counter are all 0, and the FSM is in PRIME.
- Latency: if edge k is the first edge sampling the new `sig_in` level, `evt_pulse`, `pending` and `evt_cnt` update at edge k+SYNC_STAGES.
- `irq` follows `pending` in the same cycle.
- Minimum input pulse width for guaranteed detection of both edges: 1 clock period per level. Narrower pulses may be missed entirely. A miss is never a half event.
- Throughput: one event per channel per cycle. Alternating input every cycle in mode 11 yields a continuous pulse train.
- `rst` mid-operation: all state returns to reset values at that edge, and PRIME restarts.

## Structure
- Package `edge_event_pkg`: mode encodings (`MODE_OFF`, `MODE_RISE`, `MODE_FALL`, `MODE_ANY`) and the FSM state encoding.
- Sub-module `event_channel`: one channel, containing sync chain, `prev`, detection, pending/overflow and the saturating counter. It takes `arm` from the top.
- Top: arm FSM, generate loop over CHANNELS, `irq` reduction.

## Test plan
- Reset-static-high: SYNC_STAGES=2, `sig_in`=4'b1111 through reset, mode all 11, held 20 cycles → no `evt_pulse`, all counts 0, `irq`=0.
- Latency and mode: ch0 mode 01, ch1 mode 10, `sig_in[1:0]` 0→1 sampled at edge k → `evt_pulse`=01 at edge k+2; 1→0 → `evt_pulse`=10. `evt_cnt` ch0=1, ch1=1.
- Pending/overflow/ack: ch2 mode 11, two toggles without ack → `pending[2]`=1, `overflow[2]`=1. Ack alone → both 0. Ack in the same cycle as a third event → `pending[2]`=1, `overflow[2]`=0.
- Saturation: CNT_W=2, 5 toggles in mode 11 → count 3, held. `cnt_clr` coincident with a toggle → count 1.
- Back-to-back: SYNC_STAGES=0, ch3 toggled every cycle for 8 cycles in mode 11 → 8 consecutive pulses, count 8.
- Mid-operation reset: counts nonzero, `rst` for 1 cycle → all outputs 0 next edge. Input toggle during PRIME → ignored.
